// File: rtl/buzzer_tone_gen_if.sv
// Request/status bundle for buzzer_tone_gen: level-held tone request in, registered status out.
interface buzzer_tone_gen_if;
    // Level protocol, no valid/ready: i_en/i_freq are sampled every rising edge and
    // held by the requester for as long as the tone is wanted; outputs are registered.
    logic [15:0] i_freq;
    logic        i_en;
    logic        o_buzz;
    logic        o_busy;
    logic        o_active;
    logic [1:0]  dbg_state;

    modport master (
        output i_freq,
        output i_en,
        input  o_buzz,
        input  o_busy,
        input  o_active,
        input  dbg_state
    );

    modport slave (
        input  i_freq,
        input  i_en,
        output o_buzz,
        output o_busy,
        output o_active,
        output dbg_state
    );
endinterface

// File: rtl/buzzer_tone_gen.sv
// Piezo square-wave generator: a serial restoring divider turns a frequency in Hz into a
// half-period in clocks, then a counter toggles o_buzz every half-period.
module buzzer_tone_gen #(
    parameter int unsigned CLK_HZ   = 100_000_000,
    parameter int unsigned MIN_FREQ = 20,
    parameter int unsigned MAX_FREQ = 20000
) (
    input  logic               i_clk,
    input  logic               i_reset,
    buzzer_tone_gen_if.slave   bus
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DIVIDE = 2'd1,
        S_PLAY   = 2'd2
    } state_e;

    localparam logic [31:0] DIVIDEND = 32'(CLK_HZ);
    localparam logic [15:0] MIN_F    = 16'(MIN_FREQ);
    localparam logic [15:0] MAX_F    = 16'(MAX_FREQ);

    state_e      state_q, state_d;
    logic [15:0] f_lat_q, f_lat_d;
    logic [31:0] hp_q, hp_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] dvd_q, dvd_d;
    logic [17:0] rem_q, rem_d;
    logic [31:0] quo_q, quo_d;
    logic [4:0]  bit_cnt_q, bit_cnt_d;
    logic        buzz_q, buzz_d;
    logic        busy_q, busy_d;
    logic        active_q, active_d;

    logic        in_range;
    logic        start_div;
    logic [17:0] divisor;
    logic [18:0] rem_shift;
    logic [18:0] rem_sub;
    logic        quo_bit;

    assign in_range = (bus.i_freq >= MIN_F) && (bus.i_freq <= MAX_F);

    // Divisor is 2*f_lat so the quotient is directly the half-period in clocks.
    assign divisor   = {1'b0, f_lat_q, 1'b0};
    assign rem_shift = {rem_q, dvd_q[31]};
    assign rem_sub   = rem_shift - {1'b0, divisor};
    assign quo_bit   = (rem_shift >= {1'b0, divisor});

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q   <= S_IDLE;
            f_lat_q   <= '0;
            hp_q      <= '0;
            cnt_q     <= '0;
            dvd_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            bit_cnt_q <= '0;
            buzz_q    <= 1'b0;
            busy_q    <= 1'b0;
            active_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            f_lat_q   <= f_lat_d;
            hp_q      <= hp_d;
            cnt_q     <= cnt_d;
            dvd_q     <= dvd_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            bit_cnt_q <= bit_cnt_d;
            buzz_q    <= buzz_d;
            busy_q    <= busy_d;
            active_q  <= active_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        f_lat_d   = f_lat_q;
        hp_d      = hp_q;
        cnt_d     = cnt_q;
        dvd_d     = dvd_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        bit_cnt_d = bit_cnt_q;
        buzz_d    = buzz_q;
        busy_d    = busy_q;
        active_d  = active_q;
        start_div = 1'b0;

        case (state_q)
            S_IDLE: begin
                buzz_d   = 1'b0;
                busy_d   = 1'b0;
                active_d = 1'b0;
                if (bus.i_en && in_range) begin
                    start_div = 1'b1;
                end
            end

            S_DIVIDE: begin
                if (!bus.i_en) begin
                    state_d   = S_IDLE;
                    dvd_d     = '0;
                    rem_d     = '0;
                    quo_d     = '0;
                    bit_cnt_d = '0;
                    buzz_d    = 1'b0;
                    busy_d    = 1'b0;
                    active_d  = 1'b0;
                end else begin
                    rem_d     = quo_bit ? rem_sub[17:0] : rem_shift[17:0];
                    dvd_d     = {dvd_q[30:0], 1'b0};
                    quo_d     = {quo_q[30:0], quo_bit};
                    bit_cnt_d = bit_cnt_q + 5'd1;
                    if (bit_cnt_q == 5'd31) begin
                        state_d  = S_PLAY;
                        hp_d     = {quo_q[30:0], quo_bit};
                        cnt_d    = '0;
                        buzz_d   = 1'b0;
                        busy_d   = 1'b0;
                        active_d = 1'b1;
                    end
                end
            end

            S_PLAY: begin
                if (!bus.i_en || !in_range) begin
                    state_d  = S_IDLE;
                    cnt_d    = '0;
                    buzz_d   = 1'b0;
                    busy_d   = 1'b0;
                    active_d = 1'b0;
                end else if (bus.i_freq != f_lat_q) begin
                    start_div = 1'b1;
                end else if (cnt_q == hp_q - 32'd1) begin
                    buzz_d = ~buzz_q;
                    cnt_d  = '0;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end

            default: begin
                state_d  = S_IDLE;
                buzz_d   = 1'b0;
                busy_d   = 1'b0;
                active_d = 1'b0;
            end
        endcase

        if (start_div) begin
            state_d   = S_DIVIDE;
            f_lat_d   = bus.i_freq;
            dvd_d     = DIVIDEND;
            rem_d     = '0;
            quo_d     = '0;
            bit_cnt_d = '0;
            cnt_d     = '0;
            buzz_d    = 1'b0;
            busy_d    = 1'b1;
            active_d  = 1'b0;
        end
    end

    assign bus.o_buzz    = buzz_q;
    assign bus.o_busy    = busy_q;
    assign bus.o_active  = active_q;
    assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_buzzer_tone_gen.sv
// Directed bench for buzzer_tone_gen: default-clock instance plus two small-clock instances.
module tb_buzzer_tone_gen;

    logic clk = 1'b0;
    logic rst;
    int   tests_run    = 0;
    int   tests_failed = 0;

    always #5 clk = ~clk;

    buzzer_tone_gen_if bus_m ();
    buzzer_tone_gen_if bus_f ();
    buzzer_tone_gen_if bus_s ();

    buzzer_tone_gen dut_m (.i_clk(clk), .i_reset(rst), .bus(bus_m));
    buzzer_tone_gen #(.CLK_HZ(40000)) dut_f (.i_clk(clk), .i_reset(rst), .bus(bus_f));
    buzzer_tone_gen #(.CLK_HZ(1000), .MAX_FREQ(500)) dut_s (.i_clk(clk), .i_reset(rst), .bus(bus_s));

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        rst = 1'b1;
        bus_m.i_en = 1'b0; bus_m.i_freq = '0;
        bus_f.i_en = 1'b0; bus_f.i_freq = '0;
        bus_s.i_en = 1'b0; bus_s.i_freq = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        tests_run++;
        if (bus_m.o_buzz !== 1'b0) begin tests_failed++; $display("FAIL reset_buzz: got %b want 0", bus_m.o_buzz); end
        tests_run++;
        if (bus_m.o_busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b want 0", bus_m.o_busy); end
        tests_run++;
        if (bus_m.o_active !== 1'b0) begin tests_failed++; $display("FAIL reset_active: got %b want 0", bus_m.o_active); end
        tests_run++;
        if (bus_m.dbg_state !== 2'd0) begin tests_failed++; $display("FAIL reset_state: got %0d want 0", bus_m.dbg_state); end
        tests_run++;
        if (dut_m.hp_q !== 32'd0) begin tests_failed++; $display("FAIL reset_hp: got %0d want 0", dut_m.hp_q); end
    endtask

    task automatic test_tone_1046();
        int bad;
        bus_m.i_freq = 16'd1046;
        bus_m.i_en   = 1'b1;
        bad = 0;
        repeat (32) begin
            @(negedge clk);
            if (bus_m.o_busy !== 1'b1 || bus_m.o_active !== 1'b0 || bus_m.o_buzz !== 1'b0) bad++;
        end
        tests_run++;
        if (bad !== 0) begin tests_failed++; $display("FAIL tone_divide_busy: got %0d bad cycles want 0", bad); end
        @(negedge clk);
        tests_run++;
        if (bus_m.o_active !== 1'b1 || bus_m.o_busy !== 1'b0) begin
            tests_failed++; $display("FAIL tone_enter_play: got active=%b busy=%b want 1 0", bus_m.o_active, bus_m.o_busy);
        end
        tests_run++;
        if (dut_m.hp_q !== 32'd47801) begin tests_failed++; $display("FAIL tone_hp_1046: got %0d want 47801", dut_m.hp_q); end
        bad = 0;
        repeat (47800) begin
            @(negedge clk);
            if (bus_m.o_buzz !== 1'b0 || bus_m.o_active !== 1'b1) bad++;
        end
        tests_run++;
        if (bad !== 0) begin tests_failed++; $display("FAIL tone_low_phase: got %0d bad cycles want 0", bad); end
        @(negedge clk);
        tests_run++;
        if (bus_m.o_buzz !== 1'b1) begin tests_failed++; $display("FAIL tone_first_rise: got %b want 1", bus_m.o_buzz); end
    endtask

    task automatic test_retune();
        int bad;
        bus_m.i_freq = 16'd1318;
        bad = 0;
        repeat (32) begin
            @(negedge clk);
            if (bus_m.o_busy !== 1'b1 || bus_m.o_buzz !== 1'b0) bad++;
        end
        tests_run++;
        if (bad !== 0) begin tests_failed++; $display("FAIL retune_1318_divide: got %0d bad cycles want 0", bad); end
        @(negedge clk);
        tests_run++;
        if (dut_m.hp_q !== 32'd37936 || bus_m.o_active !== 1'b1) begin
            tests_failed++; $display("FAIL retune_hp_1318: got %0d active=%b want 37936 1", dut_m.hp_q, bus_m.o_active);
        end
        bus_m.i_freq = 16'd1569;
        repeat (32) @(negedge clk);
        @(negedge clk);
        tests_run++;
        if (dut_m.hp_q !== 32'd31867 || bus_m.o_active !== 1'b1) begin
            tests_failed++; $display("FAIL retune_hp_1569: got %0d active=%b want 31867 1", dut_m.hp_q, bus_m.o_active);
        end
        bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (bus_m.o_busy !== 1'b0 || bus_m.o_active !== 1'b1) bad++;
        end
        tests_run++;
        if (bad !== 0) begin tests_failed++; $display("FAIL same_freq_no_redivide: got %0d bad cycles want 0", bad); end
    endtask

    task automatic test_out_of_range();
        logic [15:0] bad_freqs [4];
        logic [15:0] edge_freqs [2];
        int bad;
        bad_freqs  = '{16'd0, 16'd25000, 16'd19, 16'd20001};
        edge_freqs = '{16'd20, 16'd20000};
        bus_m.i_en = 1'b0;
        @(negedge clk);
        tests_run++;
        if (bus_m.dbg_state !== 2'd0 || bus_m.o_active !== 1'b0) begin
            tests_failed++; $display("FAIL play_exit_en0: got state=%0d active=%b want 0 0", bus_m.dbg_state, bus_m.o_active);
        end
        for (int i = 0; i < 4; i++) begin
            bus_m.i_freq = bad_freqs[i];
            bus_m.i_en   = 1'b1;
            bad = 0;
            repeat (4) begin
                @(negedge clk);
                if (bus_m.o_busy !== 1'b0 || bus_m.o_active !== 1'b0 || bus_m.o_buzz !== 1'b0 || bus_m.dbg_state !== 2'd0) bad++;
            end
            tests_run++;
            if (bad !== 0) begin tests_failed++; $display("FAIL out_of_range_%0d: got %0d bad cycles want 0", bad_freqs[i], bad); end
        end
        for (int i = 0; i < 2; i++) begin
            bus_m.i_freq = edge_freqs[i];
            bus_m.i_en   = 1'b1;
            @(negedge clk);
            tests_run++;
            if (bus_m.o_busy !== 1'b1) begin tests_failed++; $display("FAIL in_range_edge_%0d: got busy=%b want 1", edge_freqs[i], bus_m.o_busy); end
            bus_m.i_en = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic test_abort_divide();
        int bad;
        bus_m.i_freq = 16'd1046;
        bus_m.i_en   = 1'b1;
        repeat (10) @(negedge clk);
        bus_m.i_en = 1'b0;
        @(negedge clk);
        tests_run++;
        if (bus_m.o_busy !== 1'b0 || bus_m.dbg_state !== 2'd0 || bus_m.o_buzz !== 1'b0) begin
            tests_failed++; $display("FAIL abort_divide: got busy=%b state=%0d buzz=%b want 0 0 0", bus_m.o_busy, bus_m.dbg_state, bus_m.o_buzz);
        end
        tests_run++;
        if (dut_m.quo_q !== 32'd0) begin tests_failed++; $display("FAIL abort_discard_quo: got %0h want 0", dut_m.quo_q); end
        bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (bus_m.o_active !== 1'b0 || bus_m.o_busy !== 1'b0) bad++;
        end
        tests_run++;
        if (bad !== 0) begin tests_failed++; $display("FAIL abort_stays_idle: got %0d bad cycles want 0", bad); end
    endtask

    task automatic test_play_small();
        int bad;
        bus_s.i_freq = 16'd100;
        bus_s.i_en   = 1'b1;
        repeat (32) @(negedge clk);
        bad = 0;
        for (int j = 0; j <= 26; j++) begin
            @(negedge clk);
            if (bus_s.o_buzz !== 1'(((j / 5) % 2)) || bus_s.o_active !== 1'b1) bad++;
        end
        tests_run++;
        if (bad !== 0) begin tests_failed++; $display("FAIL small_waveform: got %0d bad cycles want 0", bad); end
        tests_run++;
        if (dut_s.hp_q !== 32'd5) begin tests_failed++; $display("FAIL small_hp: got %0d want 5", dut_s.hp_q); end
        bus_s.i_en = 1'b0;
        @(negedge clk);
        tests_run++;
        if (bus_s.o_buzz !== 1'b0 || bus_s.o_active !== 1'b0 || bus_s.dbg_state !== 2'd0) begin
            tests_failed++; $display("FAIL exit_mid_high: got buzz=%b active=%b state=%0d want 0 0 0", bus_s.o_buzz, bus_s.o_active, bus_s.dbg_state);
        end
        bad = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus_s.o_buzz !== 1'b0) bad++;
        end
        tests_run++;
        if (bad !== 0) begin tests_failed++; $display("FAIL no_toggle_after_exit: got %0d bad cycles want 0", bad); end
    endtask

    task automatic test_retune_in_divide();
        int bad;
        bus_s.i_freq = 16'd100;
        bus_s.i_en   = 1'b1;
        repeat (5) @(negedge clk);
        bus_s.i_freq = 16'd50;
        repeat (27) @(negedge clk);
        @(negedge clk);
        tests_run++;
        if (bus_s.o_active !== 1'b1 || dut_s.hp_q !== 32'd5) begin
            tests_failed++; $display("FAIL pending_retune_play: got active=%b hp=%0d want 1 5", bus_s.o_active, dut_s.hp_q);
        end
        @(negedge clk);
        tests_run++;
        if (bus_s.o_busy !== 1'b1 || bus_s.o_active !== 1'b0) begin
            tests_failed++; $display("FAIL pending_retune_divide: got busy=%b active=%b want 1 0", bus_s.o_busy, bus_s.o_active);
        end
        repeat (31) @(negedge clk);
        @(negedge clk);
        tests_run++;
        if (dut_s.hp_q !== 32'd10 || bus_s.o_active !== 1'b1) begin
            tests_failed++; $display("FAIL pending_retune_hp: got %0d active=%b want 10 1", dut_s.hp_q, bus_s.o_active);
        end
        bad = 0;
        repeat (9) begin
            @(negedge clk);
            if (bus_s.o_buzz !== 1'b0) bad++;
        end
        @(negedge clk);
        if (bus_s.o_buzz !== 1'b1) bad++;
        tests_run++;
        if (bad !== 0) begin tests_failed++; $display("FAIL pending_retune_rise: got %0d bad cycles want 0", bad); end
        bus_s.i_en = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_play();
        int bad;
        bus_s.i_freq = 16'd100;
        bus_s.i_en   = 1'b1;
        repeat (32) @(negedge clk);
        repeat (6) @(negedge clk);
        tests_run++;
        if (bus_s.o_buzz !== 1'b1) begin tests_failed++; $display("FAIL pre_reset_high: got %b want 1", bus_s.o_buzz); end
        #2;
        rst = 1'b1;
        #1;
        tests_run++;
        if (bus_s.o_buzz !== 1'b0 || bus_s.o_active !== 1'b0 || bus_s.dbg_state !== 2'd0) begin
            tests_failed++; $display("FAIL async_reset: got buzz=%b active=%b state=%0d want 0 0 0", bus_s.o_buzz, bus_s.o_active, bus_s.dbg_state);
        end
        tests_run++;
        if (dut_s.hp_q !== 32'd0 || dut_s.cnt_q !== 32'd0) begin
            tests_failed++; $display("FAIL reset_clears_regs: got hp=%0d cnt=%0d want 0 0", dut_s.hp_q, dut_s.cnt_q);
        end
        @(negedge clk);
        rst = 1'b0;
        bad = 0;
        repeat (32) begin
            @(negedge clk);
            if (bus_s.o_busy !== 1'b1 || bus_s.o_active !== 1'b0) bad++;
        end
        tests_run++;
        if (bad !== 0) begin tests_failed++; $display("FAIL restart_divide: got %0d bad cycles want 0", bad); end
        @(negedge clk);
        tests_run++;
        if (bus_s.o_active !== 1'b1 || bus_s.o_busy !== 1'b0) begin
            tests_failed++; $display("FAIL restart_play: got active=%b busy=%b want 1 0", bus_s.o_active, bus_s.o_busy);
        end
        bus_s.i_en = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_fast_toggle();
        int bad;
        bus_f.i_freq = 16'd20000;
        bus_f.i_en   = 1'b1;
        repeat (32) @(negedge clk);
        bad = 0;
        for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            if (bus_f.o_buzz !== 1'(j % 2)) bad++;
        end
        tests_run++;
        if (dut_f.hp_q !== 32'd1) begin tests_failed++; $display("FAIL fast_hp: got %0d want 1", dut_f.hp_q); end
        tests_run++;
        if (bad !== 0) begin tests_failed++; $display("FAIL fast_toggle: got %0d bad cycles want 0", bad); end
        bus_f.i_en = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_tone_1046();
        test_retune();
        test_out_of_range();
        test_abort_divide();
        test_play_small();
        test_retune_in_divide();
        test_reset_mid_play();
        test_fast_toggle();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
